// File: rtl/mem2reg_array.sv
// Flip-flop register array with indexed write, increment-all and an index-init sweep.
// Build option: define MEM2REG_ARRAY_SAT_EN to make increment-all saturate instead of wrap.
module mem2reg_array #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_SWEEP = 2'b11;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             wr_hit;

    assign busy      = (state_q == ST_SWEEP);
    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // Address decode by enumeration so out-of-range addresses simply match nothing.
    always_comb begin
        wr_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (addr == AW'(i)) wr_hit = 1'b1;
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (raddr_a == AW'(i)) rdata_a = mem_q[i];
            if (raddr_b == AW'(i)) rdata_b = mem_q[i];
        end
    end

    // Next-state: commands only act while idle; the sweep owns the array otherwise.
    always_comb begin
        mem_d   = mem_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            for (int i = 0; i < int'(DEPTH); i++) begin
                                if (addr == AW'(i)) mem_d[i] = wdata;
                            end
                            err_d = !wr_hit;
                        end
                        OP_INC: begin
                            for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef MEM2REG_ARRAY_SAT_EN
                                if (!(&mem_q[i])) mem_d[i] = mem_q[i] + WIDTH'(1);
`else
                                mem_d[i] = mem_q[i] + WIDTH'(1);
`endif
                            end
                        end
                        OP_SWEEP: begin
                            state_d = ST_SWEEP;
                            ptr_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SWEEP: begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (ptr_q == AW'(i)) mem_d[i] = WIDTH'(ptr_q);
                end
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= WIDTH'(i);
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
